// File: rtl/sprite_scan_ctrl.sv
// Per-scanline sprite scheduler: walks sprite RAM, applies the Y-hit test,
// fetches two 4bpp ROM half-rows per hit sprite and streams pixels to the
// line buffer. All state advances on clk_49m edges qualified by cen_6m.
module sprite_scan_ctrl #(
  parameter int NUM_SPR = 24,
  parameter int IDX_W   = 5
) (
  input  logic             clk_49m,
  input  logic             reset,
  input  logic             cen_6m,
  input  logic             line_start,
  input  logic [7:0]       vcnt,
  output logic [IDX_W+1:0] spr_addr,
  input  logic [7:0]       spr_data,
  output logic             rom_req,
  output logic [12:0]      rom_addr,
  input  logic             rom_ack,
  input  logic [31:0]      rom_data,
  output logic             lb_we,
  output logic [7:0]       lb_x,
  output logic [3:0]       lb_pix,
  output logic [3:0]       lb_color,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  typedef enum logic [3:0] {
    S_IDLE, S_FY, S_FA, S_FC, S_FX, S_FL, S_REQ, S_DRAW, S_NEXT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       vcnt_l;
  logic [3:0]       row;
  logic             hflip;
  logic [3:0]       color;
  logic [7:0]       code;
  logic [7:0]       xpos;
  logic             half;
  logic             second;
  logic [2:0]       p;
  logic [31:0]      data;
  logic             we_q;

  logic [7:0]       sum;
  logic             last;
  logic [IDX_W-1:0] idx_nxt;
  logic [31:0]      pix_word;
  logic [2:0]       pix_sel;
  logic [3:0]       pix_nib;
  logic [7:0]       pix_x;

  // Hit arithmetic and selection of the next pixel to present on the line buffer.
  // The first pixel of a half comes straight from rom_data on the ack tick.
  always_comb begin
    sum     = spr_data + vcnt_l;
    last    = (idx == IDX_W'(NUM_SPR - 1));
    idx_nxt = idx + IDX_W'(1);
    if (state == S_REQ) begin
      pix_word = rom_data;
      pix_sel  = '0;
    end else begin
      pix_word = data;
      pix_sel  = p + 3'd1;
    end
    pix_nib = hflip ? pix_word[{pix_sel, 2'b00} +: 4] : pix_word[{~pix_sel, 2'b00} +: 4];
    pix_x   = xpos + {4'b0000, second, pix_sel};
  end

  // Write strobe is suppressed whenever the pixel enable is low.
  always_comb begin
    lb_we = we_q & cen_6m;
  end

  // Scan state machine with registered outputs.
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      vcnt_l   <= '0;
      row      <= '0;
      hflip    <= 1'b0;
      color    <= '0;
      code     <= '0;
      xpos     <= '0;
      half     <= 1'b0;
      second   <= 1'b0;
      p        <= '0;
      data     <= '0;
      we_q     <= 1'b0;
      spr_addr <= '0;
      rom_req  <= 1'b0;
      rom_addr <= '0;
      lb_x     <= '0;
      lb_pix   <= '0;
      lb_color <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else if (cen_6m) begin
      done     <= 1'b0;
      overrun  <= 1'b0;
      we_q     <= 1'b0;
      lb_x     <= '0;
      lb_pix   <= '0;
      lb_color <= '0;
      if (line_start) begin
        // A new line always restarts the walk; it pre-empts any done this tick.
        overrun  <= (state != S_IDLE);
        vcnt_l   <= vcnt;
        idx      <= '0;
        busy     <= 1'b1;
        rom_req  <= 1'b0;
        spr_addr <= '0;
        state    <= S_FY;
      end else begin
        case (state)
          S_IDLE: ;
          S_FY: begin
            spr_addr <= {idx, 2'd1};
            state    <= S_FA;
          end
          S_FA: begin
            if (sum[7:4] == 4'hF) begin
              row      <= sum[3:0];
              spr_addr <= {idx, 2'd2};
              state    <= S_FC;
            end else if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              idx      <= idx_nxt;
              spr_addr <= {idx_nxt, 2'd0};
              state    <= S_FY;
            end
          end
          S_FC: begin
            row      <= row ^ {4{spr_data[7]}};
            hflip    <= spr_data[6];
            color    <= spr_data[3:0];
            spr_addr <= {idx, 2'd3};
            state    <= S_FX;
          end
          S_FX: begin
            code  <= spr_data;
            state <= S_FL;
          end
          S_FL: begin
            xpos     <= spr_data;
            half     <= hflip;
            second   <= 1'b0;
            rom_req  <= 1'b1;
            rom_addr <= {code, row, hflip};
            state    <= S_REQ;
          end
          S_REQ: begin
            if (rom_ack) begin
              data     <= rom_data;
              rom_req  <= 1'b0;
              p        <= '0;
              we_q     <= (pix_nib != 4'd0);
              lb_pix   <= pix_nib;
              lb_x     <= pix_x;
              lb_color <= color;
              state    <= S_DRAW;
            end
          end
          S_DRAW: begin
            if (p != 3'd7) begin
              p        <= pix_sel;
              we_q     <= (pix_nib != 4'd0);
              lb_pix   <= pix_nib;
              lb_x     <= pix_x;
              lb_color <= color;
            end else if (!second) begin
              second   <= 1'b1;
              half     <= ~half;
              rom_req  <= 1'b1;
              rom_addr <= {code, row, ~half};
              state    <= S_REQ;
            end else begin
              state <= S_NEXT;
            end
          end
          S_NEXT: begin
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              idx      <= idx_nxt;
              spr_addr <= {idx_nxt, 2'd0};
              state    <= S_FY;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
